mig_write_issuer: RTL and testbench

//  Drains the clk_ram side of the arbiter's CDC FIFOs (30b {cmd,addr} FIFO + 256b write-data FIFO) into the MIG app port.
//  Per command: pops one {cmd,addr}; for writes also pops two 256b data beats (one 512b BL8 burst), then runs the
//  app_en/app_rdy and app_wdf_wren/app_wdf_rdy handshakes independently. Exports burst/stall/timeout status.

---
 rtl/mig_write_issuer.sv | 136 +++++++++++++
 tb/tb_mig_write_issuer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_write_issuer.sv
// Drains the clk_ram side of the arbiter CDC FIFOs into the MIG app port: one BL8 write
// burst per command, with independent command and write-data handshakes.
module mig_write_issuer #(
   parameter int ADDR_WIDTH = 29,
   parameter int DATA_WIDTH = 256,
   parameter int TIMEOUT    = 4096
) (
   input  logic                    clk_ram,
   input  logic                    rst_n,
   input  logic                    calib_done,
   output logic                    cmd_fifo_rd_en,
   input  logic [ADDR_WIDTH:0]     cmd_fifo_rd_data,
   input  logic [8:0]              cmd_fifo_rd_size,
   output logic                    data_fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]   data_fifo_rd_data,
   input  logic [9:0]              data_fifo_rd_size,
   output logic [ADDR_WIDTH-1:0]   app_addr,
   output logic [2:0]              app_cmd,
   output logic                    app_en,
   input  logic                    app_rdy,
   output logic [DATA_WIDTH-1:0]   app_wdf_data,
   output logic                    app_wdf_end,
   output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   output logic                    app_wdf_wren,
   input  logic                    app_wdf_rdy,
   output logic                    busy,
   output logic [31:0]             burst_count,
   output logic [31:0]             stall_count,
   output logic                    timeout_err
);
   typedef enum logic [1:0] {IDLE, FETCH, CAPT, ISSUE} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t                  state, state_nxt;
   logic                    carry;
   logic                    cmd_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   beat0_r, beat1_r;
   logic [15:0]             iss_cnt;
   logic                    start_ok, cmd_fin, data_fin, cmd_acc, data_acc, stall;

   assign app_wdf_mask = '0;
   assign busy         = (state != IDLE);
   assign cmd_acc      = app_en && app_rdy;
   assign data_acc     = app_wdf_wren && app_wdf_rdy;
   assign cmd_fin      = !app_en || app_rdy;
   assign data_fin     = !app_wdf_wren || (app_wdf_end && app_wdf_rdy);
   assign stall        = (app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy);

   // A carried beat0 (left over from a read command) means only one more beat is needed.
   assign start_ok = calib_done && (cmd_fifo_rd_size != 9'd0) &&
                     (carry ? (data_fifo_rd_size != 10'd0) : (data_fifo_rd_size >= 10'd2));

   always_comb begin
      state_nxt       = state;
      cmd_fifo_rd_en  = 1'b0;
      data_fifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               cmd_fifo_rd_en  = 1'b1;
               data_fifo_rd_en = !carry;
               state_nxt       = FETCH;
            end
         end
         FETCH: begin
            data_fifo_rd_en = !cmd_fifo_rd_data[ADDR_WIDTH];
            state_nxt       = CAPT;
         end
         CAPT:    state_nxt = ISSUE;
         ISSUE:   if (cmd_fin && data_fin) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_ram or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         carry        <= 1'b0;
         app_addr     <= '0;
         app_cmd      <= '0;
         app_en       <= 1'b0;
         app_wdf_data <= '0;
         app_wdf_end  <= 1'b0;
         app_wdf_wren <= 1'b0;
         burst_count  <= '0;
         stall_count  <= '0;
         iss_cnt      <= '0;
         timeout_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            FETCH: carry <= cmd_fifo_rd_data[ADDR_WIDTH];
            CAPT: begin
               app_en       <= 1'b1;
               app_addr     <= addr_r;
               app_cmd      <= {2'b00, cmd_r};
               app_wdf_wren <= !cmd_r;
               app_wdf_data <= beat0_r;
               app_wdf_end  <= 1'b0;
               iss_cnt      <= '0;
            end
            ISSUE: begin
               if (cmd_acc) begin
                  app_en      <= 1'b0;
                  burst_count <= burst_count + 32'd1;
               end
               if (data_acc) begin
                  if (app_wdf_end) begin
                     app_wdf_wren <= 1'b0;
                     app_wdf_end  <= 1'b0;
                  end else begin
                     app_wdf_data <= beat1_r;
                     app_wdf_end  <= 1'b1;
                  end
               end
               if (stall) stall_count <= stall_count + 32'd1;
               // iss_cnt holds completed ISSUE cycles; the flag lands as the TIMEOUT-th one ends.
               if (iss_cnt != 16'hFFFF) iss_cnt <= iss_cnt + 16'd1;
               if (iss_cnt == TO_LAST) timeout_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_ram) begin
      if (state == FETCH) begin
         cmd_r  <= cmd_fifo_rd_data[ADDR_WIDTH];
         addr_r <= cmd_fifo_rd_data[ADDR_WIDTH-1:0];
         if (!carry) beat0_r <= data_fifo_rd_data;
      end
      if (state == CAPT) beat1_r <= data_fifo_rd_data;
   end
endmodule

// File: tb/tb_mig_write_issuer.sv
// Bench for mig_write_issuer: FIFO/MIG models, table-driven single bursts, corner sequences
// and a randomized stream scored against an in-order command/data reference.
module tb_mig_write_issuer;
   localparam int AW = 29;
   localparam int DW = 256;
   localparam int TO = 16;
   localparam int NV = 6;

   typedef struct {
      logic [AW-1:0] addr;
      int            n_lo;
      int            m_lo;
      int            exp_en;
      int            exp_w0;
      int            exp_stall;
   } vec_t;

   logic            clk_ram = 1'b0;
   logic            rst_n;
   logic            calib_done;
   logic            cmd_fifo_rd_en;
   logic [AW:0]     cmd_fifo_rd_data;
   logic [8:0]      cmd_fifo_rd_size;
   logic            data_fifo_rd_en;
   logic [DW-1:0]   data_fifo_rd_data;
   logic [9:0]      data_fifo_rd_size;
   logic [AW-1:0]   app_addr;
   logic [2:0]      app_cmd;
   logic            app_en;
   logic            app_rdy;
   logic [DW-1:0]   app_wdf_data;
   logic            app_wdf_end;
   logic [DW/8-1:0] app_wdf_mask;
   logic            app_wdf_wren;
   logic            app_wdf_rdy;
   logic            busy;
   logic [31:0]     burst_count;
   logic [31:0]     stall_count;
   logic            timeout_err;

   always #5 clk_ram = ~clk_ram;

   mig_write_issuer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk_ram(clk_ram), .rst_n(rst_n), .calib_done(calib_done),
      .cmd_fifo_rd_en(cmd_fifo_rd_en), .cmd_fifo_rd_data(cmd_fifo_rd_data),
      .cmd_fifo_rd_size(cmd_fifo_rd_size),
      .data_fifo_rd_en(data_fifo_rd_en), .data_fifo_rd_data(data_fifo_rd_data),
      .data_fifo_rd_size(data_fifo_rd_size),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_rdy(app_wdf_rdy),
      .busy(busy), .burst_count(burst_count), .stall_count(stall_count),
      .timeout_err(timeout_err)
   );

   int errors = 0;
   int checks = 0;

   logic [AW:0]   cq[$];
   logic [DW-1:0] dq[$];
   logic [AW:0]   exp_c[$];
   logic [DW-1:0] exp_d[$];
   logic          exp_end = 1'b0;
   int            exp_burst = 0;
   int            exp_stall = 0;
   int            m_stall = 0;

   int rdy_mode = 0;
   int n_lo = 0, m_lo = 0, iss_c = 0, lo_c = 0, lo_d = 0;
   int cyc = 0, en_cyc = 0, w0_cyc = 0, w1_cyc = 0, addr_bad = 0, rden_cyc = 0, busy_cyc = 0;
   int pop_at = -1, first_en = -1, last_pop = -1;
   int gaps[$];
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] mask_ref = '0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic [DW-1:0] rnd_beat();
      logic [DW-1:0] r;
      for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic upd_sizes();
      cmd_fifo_rd_size  = 9'(cq.size());
      data_fifo_rd_size = 10'(dq.size());
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] b0, input logic [DW-1:0] b1);
      cq.push_back({1'b0, a});
      exp_c.push_back({1'b0, a});
      dq.push_back(b0); dq.push_back(b1);
      exp_d.push_back(b0); exp_d.push_back(b1);
      exp_burst++;
      upd_sizes();
   endtask

   task automatic push_rd(input logic [AW-1:0] a);
      cq.push_back({1'b1, a});
      exp_c.push_back({1'b1, a});
      exp_burst++;
      upd_sizes();
   endtask

   // One clock: observe at the falling edge, then model FIFO pops and drive ready after the rise.
   task automatic tick();
      logic       cp, dp;
      logic [AW:0] e;
      @(negedge clk_ram);
      cp = cmd_fifo_rd_en;
      dp = data_fifo_rd_en;
      if (cp || dp) rden_cyc++;
      if (busy) busy_cyc++;
      if (cp) begin
         pop_at = cyc;
         if (last_pop >= 0) gaps.push_back(cyc - last_pop);
         last_pop = cyc;
      end
      if (app_en && first_en < 0) first_en = cyc;
      if (app_en) begin
         en_cyc++;
         if (app_addr !== cur_addr) addr_bad++;
      end
      if (app_en || app_wdf_wren) iss_c++;
      if (app_wdf_wren) begin
         if (app_wdf_end) w1_cyc++;
         else w0_cyc++;
      end
      if ((app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy)) m_stall++;
      if (app_en && app_rdy) begin
         if (exp_c.size() == 0) chk("cmd_unexpected", DW'(1), DW'(0));
         else begin
            e = exp_c.pop_front();
            chk("cmd_word", DW'({app_cmd, app_addr}), DW'({2'b00, e}));
         end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
         if (exp_d.size() == 0) chk("data_unexpected", DW'(1), DW'(0));
         else begin
            chk("wdf_data", app_wdf_data, exp_d.pop_front());
            chk("wdf_end", DW'(app_wdf_end), DW'(exp_end));
            exp_end = !exp_end;
         end
      end
      @(posedge clk_ram);
      #1;
      cyc++;
      if (cp) begin
         if (cq.size() == 0) chk("cmd_underflow", DW'(1), DW'(0));
         else cmd_fifo_rd_data = cq.pop_front();
      end
      if (dp) begin
         if (dq.size() == 0) chk("data_underflow", DW'(1), DW'(0));
         else data_fifo_rd_data = dq.pop_front();
      end
      upd_sizes();
      if (rdy_mode == 0) begin
         app_rdy     = (iss_c >= n_lo);
         app_wdf_rdy = (iss_c >= m_lo);
      end else begin
         app_rdy     = (lo_c >= 3) || ($urandom_range(0, 3) != 0);
         app_wdf_rdy = (lo_d >= 3) || ($urandom_range(0, 3) != 0);
         lo_c = app_rdy ? 0 : lo_c + 1;
         lo_d = app_wdf_rdy ? 0 : lo_d + 1;
      end
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((busy || exp_c.size() != 0 || exp_d.size() != 0) && n < bound);
      chk("drain_pending", DW'(busy || exp_c.size() != 0 || exp_d.size() != 0), DW'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tv[NV];
      int   n;
      tv[0] = '{29'h0000100,  0, 0,  1, 1,  0};
      tv[1] = '{29'h1ABCDEF,  5, 3,  6, 4,  5};
      tv[2] = '{29'h0000040,  0, 4,  1, 5,  4};
      tv[3] = '{29'h1FFFFFFF, 7, 0,  8, 1,  7};
      tv[4] = '{29'h0000000,  2, 2,  3, 3,  2};
      tv[5] = '{29'h0F0F0F0, 14, 0, 15, 1, 14};

      rst_n = 1'b0; calib_done = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      cmd_fifo_rd_data = '0; data_fifo_rd_data = '0;
      upd_sizes();
      repeat (3) @(negedge clk_ram);
      chk("reset_app_en", DW'(app_en), DW'(0));
      chk("reset_wren", DW'(app_wdf_wren), DW'(0));
      chk("reset_busy", DW'(busy), DW'(0));
      chk("reset_counts", DW'({burst_count, stall_count}), DW'(0));
      chk("reset_timeout", DW'(timeout_err), DW'(0));
      chk("reset_rd_en", DW'({cmd_fifo_rd_en, data_fifo_rd_en}), DW'(0));
      @(posedge clk_ram); #1;
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         rdy_mode = 0; n_lo = tv[i].n_lo; m_lo = tv[i].m_lo; iss_c = 0;
         app_rdy = (n_lo == 0); app_wdf_rdy = (m_lo == 0);
         en_cyc = 0; w0_cyc = 0; w1_cyc = 0; addr_bad = 0; first_en = -1; pop_at = -1;
         cur_addr = tv[i].addr;
         push_wr(tv[i].addr, rnd_beat(), rnd_beat());
         wait_idle(200);
         exp_stall += tv[i].exp_stall;
         chk($sformatf("v%0d_en_cycles", i), DW'(en_cyc), DW'(tv[i].exp_en));
         chk($sformatf("v%0d_beat0_cycles", i), DW'(w0_cyc), DW'(tv[i].exp_w0));
         chk($sformatf("v%0d_beat1_cycles", i), DW'(w1_cyc), DW'(1));
         chk($sformatf("v%0d_addr_stable", i), DW'(addr_bad), DW'(0));
         chk($sformatf("v%0d_latency", i), DW'(first_en - pop_at), DW'(3));
         chk($sformatf("v%0d_stall_count", i), DW'(stall_count), DW'(exp_stall));
         chk($sformatf("v%0d_burst_count", i), DW'(burst_count), DW'(exp_burst));
         chk($sformatf("v%0d_mask", i), DW'(app_wdf_mask), mask_ref);
      end
      chk("no_timeout_at_15", DW'(timeout_err), DW'(0));

      // Timeout: app_rdy withheld 30 cycles.
      n_lo = 30; m_lo = 0; iss_c = 0; app_rdy = 1'b0; app_wdf_rdy = 1'b1; en_cyc = 0;
      cur_addr = 29'h0000ABC;
      push_wr(29'h0000ABC, rnd_beat(), rnd_beat());
      n = 0;
      while (iss_c < 15 && n < 100) begin tick(); n++; end
      chk("timeout_before", DW'(timeout_err), DW'(0));
      tick();
      chk("timeout_rise", DW'(timeout_err), DW'(1));
      wait_idle(100);
      exp_stall += 30;
      chk("timeout_en_cycles", DW'(en_cyc), DW'(31));
      chk("timeout_stall", DW'(stall_count), DW'(exp_stall));
      repeat (5) tick();
      chk("timeout_sticky", DW'(timeout_err), DW'(1));

      // Asynchronous reset in the middle of ISSUE.
      n_lo = 20; m_lo = 20; iss_c = 0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      push_wr(29'h0000777, rnd_beat(), rnd_beat());
      n = 0;
      while (iss_c < 5 && n < 50) begin tick(); n++; end
      chk("rst_in_issue", DW'(app_en), DW'(1));
      @(negedge clk_ram); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_app_en", DW'(app_en), DW'(0));
      chk("rst_wren", DW'(app_wdf_wren), DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_burst_count", DW'(burst_count), DW'(0));
      chk("rst_stall_count", DW'(stall_count), DW'(0));
      chk("rst_timeout", DW'(timeout_err), DW'(0));
      chk("rst_app_addr_cmd", DW'({app_cmd, app_addr}), DW'(0));
      chk("rst_wdf_data_end", app_wdf_data | DW'(app_wdf_end), DW'(0));
      cq.delete(); dq.delete(); exp_c.delete(); exp_d.delete();
      exp_end = 1'b0; exp_burst = 0; exp_stall = 0; m_stall = 0;
      upd_sizes();
      repeat (2) @(posedge clk_ram);
      #1;
      rst_n = 1'b1; n_lo = 0; m_lo = 0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;

      // Gating: one data word short, then calibration low.
      rden_cyc = 0; busy_cyc = 0;
      cq.push_back({1'b0, 29'h0000123});
      dq.push_back(64'h1111);
      upd_sizes();
      repeat (100) tick();
      chk("gate_data_rd_en", DW'(rden_cyc), DW'(0));
      chk("gate_data_busy", DW'(busy_cyc), DW'(0));
      calib_done = 1'b0;
      dq.push_back(64'h2222);
      upd_sizes();
      repeat (100) tick();
      chk("gate_calib_rd_en", DW'(rden_cyc), DW'(0));
      chk("gate_calib_busy", DW'(busy_cyc), DW'(0));
      exp_c.push_back({1'b0, 29'h0000123});
      exp_d.push_back(64'h1111); exp_d.push_back(64'h2222);
      exp_burst++;
      calib_done = 1'b1;
      wait_idle(100);
      chk("gate_release_burst", DW'(burst_count), DW'(exp_burst));

      // Read commands: carried beat0 must land on the following write.
      push_rd(29'h0000ABC);
      push_rd(29'h0000ABD);
      push_wr(29'h0000DEF, rnd_beat(), rnd_beat());
      wait_idle(200);
      chk("carry_bursts", DW'(burst_count), DW'(exp_burst));
      chk("carry_fifos_empty", DW'(cq.size() + dq.size()), DW'(0));

      // Back-to-back writes with ready always high.
      gaps.delete(); last_pop = -1;
      for (int i = 0; i < 4; i++) push_wr(AW'(32'h100 + i), rnd_beat(), rnd_beat());
      wait_idle(100);
      chk("b2b_gap_count", DW'(gaps.size()), DW'(3));
      foreach (gaps[i]) chk($sformatf("b2b_gap%0d", i), DW'(gaps[i]), DW'(5));

      // Randomized stream of 64 writes.
      rdy_mode = 1; lo_c = 0; lo_d = 0;
      for (int i = 0; i < 64; i++) push_wr(AW'($urandom()), rnd_beat(), rnd_beat());
      wait_idle(64 * 20);
      chk("stream_burst_count", DW'(burst_count), DW'(exp_burst));
      chk("stream_stall_count", DW'(stall_count), DW'(m_stall));
      chk("stream_no_timeout", DW'(timeout_err), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
